// File: rtl/sbox_pprm_pipe.sv
// Multi-lane AES forward/inverse S-box behind a valid/ready pipeline of 1..3 register stages.
// Define SBOX_PIPE_PERF_EN to add the perf_xfers/perf_stalls counters.
module sbox_pprm_pipe #(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_data,
  input  logic                 in_encrypt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic                 out_encrypt
`ifdef SBOX_PIPE_PERF_EN
  ,
  output logic [31:0]          perf_xfers,
  output logic [31:0]          perf_stalls
`endif
);

  localparam int W    = 8 * LANES;
  localparam int LAST = PIPE_STAGES - 1;
  typedef logic [W-1:0] word_t;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // a^254 as the product a^2 * a^4 * ... * a^128; maps 0 to 0 without a special case.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic word_t xform_in(input word_t w, input logic enc);
    word_t r;
    r = w;
    if (!enc)
      for (int l = 0; l < LANES; l++) r[8*l +: 8] = inv_affine(w[8*l +: 8]);
    return r;
  endfunction

  function automatic word_t xform_inv(input word_t w);
    word_t r;
    for (int l = 0; l < LANES; l++) r[8*l +: 8] = gf_inv(w[8*l +: 8]);
    return r;
  endfunction

  function automatic word_t xform_out(input word_t w, input logic enc);
    word_t r;
    r = w;
    if (enc)
      for (int l = 0; l < LANES; l++) r[8*l +: 8] = affine(w[8*l +: 8]);
    return r;
  endfunction

  word_t                  data_q  [PIPE_STAGES];
  word_t                  stage_d [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] mode_q;
  logic [PIPE_STAGES-1:0] valid_q;
  logic [PIPE_STAGES-1:0] src_mode;
  logic [PIPE_STAGES-1:0] src_valid;
  logic [PIPE_STAGES-1:0] load;

  // A stage may load when empty or when its successor takes its content this cycle.
  always_comb begin
    logic carry;
    // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
    load         = '0;
    src_mode     = '0;
    src_valid    = '0;
    carry        = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      carry   = !valid_q[k] || carry;
      load[k] = carry;
    end
    src_valid[0] = in_valid;
    src_mode[0]  = in_encrypt;
    for (int k = 1; k < PIPE_STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_mode[k]  = mode_q[k-1];
    end
  end

  generate
    if (PIPE_STAGES == 3) begin : g_three
      always_comb begin
        stage_d[0] = xform_in(in_data, in_encrypt);
        stage_d[1] = xform_inv(data_q[0]);
        stage_d[2] = xform_out(data_q[1], mode_q[1]);
      end
    end else if (PIPE_STAGES == 2) begin : g_two
      always_comb begin
        stage_d[0] = xform_inv(xform_in(in_data, in_encrypt));
        stage_d[1] = xform_out(data_q[0], mode_q[0]);
      end
    end else if (PIPE_STAGES == 1) begin : g_one
      always_comb begin
        stage_d[0] = xform_out(xform_inv(xform_in(in_data, in_encrypt)), in_encrypt);
      end
    end else begin : g_bad
      $error("sbox_pprm_pipe: PIPE_STAGES must be 1, 2 or 3");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++)
        if (load[k]) valid_q[k] <= src_valid[k];
    end
  end

  // NOTE: inner data registers are qualified by their valid bit and need no reset;
  // only the output register is cleared so out_data/out_encrypt read 0 after reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < PIPE_STAGES; k++) begin
      if (load[k] && src_valid[k]) begin
        data_q[k] <= stage_d[k];
        mode_q[k] <= src_mode[k];
      end
    end
    if (rst) begin
      data_q[LAST] <= '0;
      mode_q[LAST] <= 1'b0;
    end
  end

  assign in_ready    = load[0] && !rst;
  assign out_valid   = valid_q[LAST];
  assign out_data    = data_q[LAST];
  assign out_encrypt = mode_q[LAST];

`ifdef SBOX_PIPE_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_xfers  <= '0;
      perf_stalls <= '0;
    end else begin
      if (out_valid && out_ready)  perf_xfers  <= perf_xfers + 32'd1;
      if (out_valid && !out_ready) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
